shift_issue: RTL and testbench

Issue and writeback stage feeding the processor's shift execution unit. Accepts 16-bit instructions through a valid/ready handshake, reads operands from an internal 8x32 register file, and drives the shifter's enable, opcode, amount and data inputs from registers. Captures the shifter's registered result and writes it back to the destination register, with stall and forward logic keeping program order correct across the two-cycle shifter round trip.

---
 rtl/shift_issue.sv | 114 +++++++++++
 tb/tb_shift_issue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue.sv
// shift_issue: issue/writeback stage for the external shift unit.
// Ports: clk, reset (async, active-low); instr_valid/instr/instr_ready
//   instruction handshake; shift_en/op/amt/data registered shifter
//   inputs; shift_result registered shifter output; dbg_addr/dbg_data
//   combinational regfile read; busy = writeback pending.
module shift_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        shift_en,
    output logic [2:0]  shift_op,
    output logic [2:0]  shift_amt,
    output logic [31:0] shift_data,
    input  logic [31:0] shift_result,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic        busy
);

    logic [31:0] regs [8];

    logic       s1_v;
    logic [2:0] s1_rd;
    logic       s2_v;
    logic [2:0] s2_rd;

    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  shamt;
    logic [31:0] imm;

    assign op    = instr[15:13];
    assign rd    = instr[12:10];
    assign rs    = instr[9:7];
    assign shamt = instr[6:4];
    assign imm   = {22'b0, instr[9:0]};

    logic is_shift;
    logic is_ldi;

    always_comb begin
        is_shift = 1'b0;
        is_ldi   = 1'b0;
        unique case (1'b1)
            !op[2]:        is_shift = 1'b1;
            op == 3'b100:  is_ldi   = 1'b1;
            default: ;
        endcase
    end

    // RAW: the source is still inside the shifter, nothing to forward yet.
    logic raw_stall;
    // WAW: an in-flight writeback must land before a younger LDI.
    logic waw_stall;

    assign raw_stall = is_shift && s1_v && (s1_rd == rs);
    assign waw_stall = is_ldi &&
                       ((s1_v && (s1_rd == rd)) ||
                        (s2_v && (s2_rd == rd)));

    assign instr_ready = reset && !raw_stall && !waw_stall;

    logic accept;
    logic issue;

    assign accept = instr_valid && instr_ready;
    assign issue  = accept && is_shift;

    // Result sitting on shift_result is newer than the regfile copy.
    logic [31:0] operand;

    assign operand = (s2_v && (s2_rd == rs)) ? shift_result : regs[rs];

    assign dbg_data = regs[dbg_addr];
    assign busy     = s1_v || s2_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            shift_en   <= 1'b0;
            shift_op   <= '0;
            shift_amt  <= '0;
            shift_data <= '0;
            s1_v       <= 1'b0;
            s1_rd      <= '0;
            s2_v       <= 1'b0;
            s2_rd      <= '0;
        end else begin
            shift_en <= issue;
            if (issue) begin
                shift_op   <= op;
                shift_amt  <= shamt;
                shift_data <= operand;
                s1_rd      <= rd;
            end
            s1_v  <= issue;
            s2_v  <= s1_v;
            s2_rd <= s1_rd;
            if (s2_v) begin
                regs[s2_rd] <= shift_result;
            end
            // WAW stall guarantees rd differs from s2_rd here.
            if (accept && is_ldi) begin
                regs[rd] <= imm;
            end
        end
    end

endmodule

// File: tb/tb_shift_issue.sv
// tb_shift_issue: scoreboard bench for shift_issue with an external
// shifter model and a program-order architectural register model.
module tb_shift_issue;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        shift_en;
    logic [2:0]  shift_op;
    logic [2:0]  shift_amt;
    logic [31:0] shift_data;
    logic [31:0] shift_result;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        busy;

    shift_issue dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .shift_en     (shift_en),
        .shift_op     (shift_op),
        .shift_amt    (shift_amt),
        .shift_data   (shift_data),
        .shift_result (shift_result),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int en_pulses = 0;

    logic [31:0] arch [8];
    logic [37:0] exp_q [$];

    function automatic logic [31:0] shf(
        input logic [2:0] o, input logic [2:0] a, input logic [31:0] d);
        case (o)
            3'd0, 3'd1: return d << a;
            3'd2:       return d >> a;
            default:    return 32'($signed(d) >>> a);
        endcase
    endfunction

    // External shifter: one registered stage.
    always @(posedge clk) begin
        if (shift_en) shift_result <= shf(shift_op, shift_amt, shift_data);
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset && shift_en) begin
            logic [37:0] e;
            en_pulses++;
            if (exp_q.size() == 0) begin
                check("issue_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("issue_op", {29'b0, shift_op}, {29'b0, e[37:35]});
                check("issue_amt", {29'b0, shift_amt}, {29'b0, e[34:32]});
                check("issue_data", shift_data, e[31:0]);
            end
        end
    end

    function automatic logic [15:0] mk(input int o, input int d,
                                       input int s, input int a);
        logic [2:0] o3, d3, s3, a3;
        o3 = 3'(o); d3 = 3'(d); s3 = 3'(s); a3 = 3'(a);
        return {o3, d3, s3, a3, 4'b0};
    endfunction

    function automatic logic [15:0] ldi(input int d, input int v);
        logic [2:0] d3;
        logic [9:0] v10;
        d3 = 3'(d); v10 = 10'(v);
        return {3'b100, d3, v10};
    endfunction

    // Program-order model: each accepted instruction updates arch state.
    task automatic model_accept(input logic [15:0] i);
        logic [2:0] o, d, s, a;
        o = i[15:13]; d = i[12:10]; s = i[9:7]; a = i[6:4];
        if (o <= 3'd3) begin
            exp_q.push_back({o, a, arch[s]});
            arch[d] = shf(o, a, arch[s]);
        end else if (o == 3'd4) begin
            arch[d] = {22'b0, i[9:0]};
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [15:0] i, output int stalls);
        instr_valid = 1'b1;
        instr = i;
        stalls = 0;
        #1;
        while (!instr_ready && stalls < 20) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (!instr_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end else begin
            model_accept(i);
            @(negedge clk);
        end
        instr_valid = 1'b0;
    endtask

    task automatic check_regs(input string nm);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check(nm, dbg_data, arch[r]);
        end
    endtask

    initial begin
        int st, b, p0, tot;
        reset = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = '0;
        shift_result = '0;
        for (int r = 0; r < 8; r++) arch[r] = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, instr_ready}, 32'd0);
        check("rst_en", {31'b0, shift_en}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_data", shift_data, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic LDI then shift left.
        send(ldi(1, 10'h005), st);
        dbg_addr = 3'd1; #1;
        check("ldi_r1", dbg_data, 32'h5);
        p0 = en_pulses;
        send(mk(0, 2, 1, 3), st);
        check("t1_en", {31'b0, shift_en}, 32'd1);
        check("t1_data", shift_data, 32'h5);
        check("t1_amt", {29'b0, shift_amt}, 32'd3);
        b = 0;
        for (int k = 0; k < 4; k++) begin
            b += int'(busy);
            @(negedge clk);
        end
        check("t1_busy_cycles", b, 32'd2);
        check("t1_pulses", en_pulses - p0, 32'd1);
        dbg_addr = 3'd2; #1;
        check("t1_r2", dbg_data, 32'h28);

        // Dependent chain with forwarding.
        send(ldi(1, 10'h3FF), st);
        send(mk(2, 2, 1, 2), st);
        send(mk(0, 3, 2, 1), st);
        check("t2_stalls", st, 32'd1);
        check("t2_fwd", shift_data, 32'hFF);
        repeat (3) @(negedge clk);
        dbg_addr = 3'd3; #1;
        check("t2_r3", dbg_data, 32'h1FE);

        // WAW: LDI behind an in-flight shift to the same register.
        send(mk(0, 4, 1, 1), st);
        send(ldi(4, 10'h100), st);
        check("t3_stalls", st, 32'd2);
        dbg_addr = 3'd4; #1;
        check("t3_r4_now", dbg_data, 32'h100);
        repeat (3) @(negedge clk);
        dbg_addr = 3'd4; #1;
        check("t3_r4", dbg_data, 32'h100);

        // Four independent shifts back to back.
        p0 = en_pulses;
        tot = 0;
        send(mk(3, 5, 1, 4), st); tot += st;
        send(mk(2, 6, 1, 7), st); tot += st;
        send(mk(1, 7, 1, 5), st); tot += st;
        send(mk(0, 0, 1, 6), st); tot += st;
        repeat (3) @(negedge clk);
        check("t4_stalls", tot, 32'd0);
        check("t4_pulses", en_pulses - p0, 32'd4);
        check_regs("t4_regs");

        // NOP.
        p0 = en_pulses;
        send(mk(7, 2, 3, 1), st);
        check("t5_stalls", st, 32'd0);
        repeat (3) @(negedge clk);
        check("t5_pulses", en_pulses - p0, 32'd0);
        check_regs("t5_regs");

        // Reset right after a shift accept.
        send(mk(0, 5, 1, 2), st);
        #2 reset = 1'b0;
        #1;
        check("t6_en", {31'b0, shift_en}, 32'd0);
        check("t6_op", {29'b0, shift_op}, 32'd0);
        check("t6_amt", {29'b0, shift_amt}, 32'd0);
        check("t6_data", shift_data, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_ready", {31'b0, instr_ready}, 32'd0);
        for (int r = 0; r < 8; r++) arch[r] = '0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_regs("t6_regs");

        // Randomized program.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ri[15:13] = 3'b100;
            if ($urandom_range(0, 4) == 0) begin
                instr_valid = 1'b0;
                @(negedge clk);
            end
            send(ri, st);
        end
        repeat (4) @(negedge clk);
        check_regs("rand_regs");
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
